// File: rtl/paper_ctrl_pkg.sv
// Shared types and helpers for the paper processor clock-pulse control path.
package paper_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OP_HLT = 2'b10;

    // A single-phase instruction still needs a one-bit phase port.
    function automatic int phase_width(input int phases);
        return (phases > 1) ? $clog2(phases) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable-driven saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run/step/halt sequencer: decides which clk cycles pass a pulse to the processor,
// tracks the phase within each instruction and counts completed instructions.
module run_ctrl
    import paper_ctrl_pkg::*;
#(
    parameter int PHASES = 2,
    parameter int CNT_W  = 16,
    localparam int PW    = phase_width(PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       instruct,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             stop_req,
    input  logic             clear_req,
    output logic             pulse_en,
    output logic [PW-1:0]    phase,
    output logic             running,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

    state_t          state_reg, state_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic            stop_pend_reg, stop_pend_next;
    logic            pulse_en_reg;
    logic            step_done_reg, step_done_next;
    logic            count_en;

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        step_done_next = 1'b0;
        count_en       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (run_req) begin
                    state_next = ST_RUN;
                    phase_next = '0;
                end else if (step_req) begin
                    state_next = ST_STEP;
                    phase_next = '0;
                end
            end
            ST_RUN, ST_STEP: begin
                // HLT is checked before completion so a single-phase HLT is never counted.
                if ((phase_reg == '0) && (instruct == OP_HLT)) begin
                    state_next = ST_HALTED;
                end else if (phase_reg == LAST_PHASE) begin
                    count_en   = 1'b1;
                    phase_next = '0;
                    if (state_reg == ST_STEP) begin
                        state_next     = ST_IDLE;
                        step_done_next = 1'b1;
                    end else if (stop_pend_reg || stop_req) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_HALTED: begin
                if (clear_req) begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A stop request is only remembered while the sequencer keeps free-running.
    assign stop_pend_next = (state_next == ST_RUN) &&
                            (stop_pend_reg || ((state_reg == ST_RUN) && stop_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            stop_pend_reg <= 1'b0;
            pulse_en_reg  <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            stop_pend_reg <= stop_pend_next;
            pulse_en_reg  <= (state_next == ST_RUN) || (state_next == ST_STEP);
            step_done_reg <= step_done_next;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_instr_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (count_en),
        .count (instr_count)
    );

    assign pulse_en  = pulse_en_reg;
    assign phase     = phase_reg;
    assign running   = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign halted    = (state_reg == ST_HALTED);
    assign step_done = step_done_reg;

endmodule
